// File: rtl/mcol_seq.sv
// mcol_seq: serial three-share MixColumns scheduler, one 4-cell column of one share per cycle.
// mcol: single-column involutive MixColumns, each output is the XOR of the other three cells.
module mcol (
  input  logic [4:0] a1,
  input  logic [4:0] a2,
  input  logic [4:0] a3,
  input  logic [4:0] a4,
  output logic [4:0] y1,
  output logic [4:0] y2,
  output logic [4:0] y3,
  output logic [4:0] y4
);
  assign y1 = a2 ^ a3 ^ a4;
  assign y2 = a1 ^ a3 ^ a4;
  assign y3 = a1 ^ a2 ^ a4;
  assign y4 = a1 ^ a2 ^ a3;
endmodule

module mcol_seq #(
  parameter int NSHARES = 3,
  parameter int NCOLS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NSHARES*160-1:0]   din,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NSHARES*160-1:0]   dout,
  output logic                     busy
);
  localparam int W = $clog2(NSHARES*160);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] LAST_SH = 2'(NSHARES-1);
  localparam logic [2:0] LAST_COL = 3'(NCOLS-1);
  logic [NSHARES*160-1:0] st;
  logic [1:0] fsm;
  logic [1:0] sh;
  logic [2:0] col;
  logic [W-1:0] base;
  logic [4:0] a1, a2, a3, a4, y1, y2, y3, y4;
  // rows of one column sit 5*NCOLS bits apart inside a share
  assign base = W'(sh) * W'(160) + W'(col) * W'(5);
  assign a1 = st[base +: 5];
  assign a2 = st[base + W'(5*NCOLS) +: 5];
  assign a3 = st[base + W'(10*NCOLS) +: 5];
  assign a4 = st[base + W'(15*NCOLS) +: 5];
  mcol u_mcol (.a1(a1), .a2(a2), .a3(a3), .a4(a4), .y1(y1), .y2(y2), .y3(y3), .y4(y4));
  assign in_ready = fsm == IDLE;
  assign busy = fsm == RUN;
  assign out_valid = fsm == DONE;
  assign dout = st;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= '0;
      sh <= '0;
      col <= '0;
      fsm <= IDLE;
    end else if (fsm == IDLE) begin
      if (in_valid) begin
        st <= din;
        sh <= '0;
        col <= '0;
        fsm <= RUN;
      end
    end else if (fsm == RUN) begin
      st[base +: 5] <= y1;
      st[base + W'(5*NCOLS) +: 5] <= y2;
      st[base + W'(10*NCOLS) +: 5] <= y3;
      st[base + W'(15*NCOLS) +: 5] <= y4;
      col <= col == LAST_COL ? '0 : col + 3'd1;
      sh <= col == LAST_COL ? (sh == LAST_SH ? '0 : sh + 2'd1) : sh;
      if (col == LAST_COL && sh == LAST_SH) fsm <= DONE;
    end else if (out_ready) fsm <= IDLE;
endmodule

// File: tb/tb_mcol_seq.sv
// tb_mcol_seq: scoreboard bench for the serial three-share MixColumns scheduler.
module tb_mcol_seq;
  logic clk = 0;
  logic rst = 1;
  logic in_valid = 0;
  logic in_ready;
  logic [479:0] din = '0;
  logic out_valid;
  logic out_ready = 0;
  logic [479:0] dout;
  logic busy;
  int asserts = 0;
  int fails = 0;
  int cyc = 0;
  int t_acc = 0;
  logic [479:0] sb[$];
  logic [159:0] sbx[$];

  mcol_seq dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // each output cell is the XOR of the whole column minus itself
  function automatic logic [159:0] mix160(input logic [159:0] s);
    logic [159:0] r;
    logic [4:0] t;
    r = '0;
    for (int c = 0; c < 8; c++) begin
      t = s[5*c +: 5] ^ s[5*(8+c) +: 5] ^ s[5*(16+c) +: 5] ^ s[5*(24+c) +: 5];
      for (int k = 0; k < 4; k++) r[5*(8*k+c) +: 5] = t ^ s[5*(8*k+c) +: 5];
    end
    return r;
  endfunction

  function automatic logic [479:0] mc_ref(input logic [479:0] d);
    return {mix160(d[320 +: 160]), mix160(d[160 +: 160]), mix160(d[0 +: 160])};
  endfunction

  function automatic logic [479:0] rnd480();
    logic [479:0] r;
    for (int i = 0; i < 15; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [479:0] d, input bit keep);
    int n;
    n = 0;
    in_valid = 1;
    din = d;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    t_acc = cyc;
    sb.push_back(mc_ref(d));
    sbx.push_back(mix160(d[0 +: 160] ^ d[160 +: 160] ^ d[320 +: 160]));
    if (!keep) in_valid = 0;
    asserts++;
    if ({busy, in_ready} !== 2'b10) begin
      fails++;
      $display("FAIL accept_flags busy/in_ready got %b exp 10", {busy, in_ready});
    end
  endtask

  task automatic collect(input int stall, output logic [479:0] got);
    int n;
    logic [479:0] exp;
    logic [479:0] held;
    bit stable;
    n = 0;
    out_ready = stall == 0;
    while (!out_valid && n < 100) begin
      asserts++;
      if (in_ready !== 1'b0) begin
        fails++;
        $display("FAIL in_ready_low got %b exp 0", in_ready);
      end
      tick();
      n++;
    end
    asserts++;
    if (!out_valid || cyc - t_acc != 24) begin
      fails++;
      $display("FAIL latency got %0d edges (out_valid %b) exp 24", cyc - t_acc, out_valid);
    end
    held = dout;
    stable = 1;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1;
      din = ~held;
      tick();
      if (out_valid !== 1'b1 || dout !== held || in_ready !== 1'b0) stable = 0;
    end
    if (stall > 0) begin
      asserts++;
      if (!stable) begin
        fails++;
        $display("FAIL backpressure_stable got dout %h exp %h", dout, held);
      end
      in_valid = 0;
    end
    out_ready = 1;
    got = dout;
    asserts++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty got 0 entries exp 1");
    end else begin
      exp = sb.pop_front();
      if (got !== exp) begin
        fails++;
        $display("FAIL dout got %h exp %h", got, exp);
      end
      asserts++;
      if ((got[0 +: 160] ^ got[160 +: 160] ^ got[320 +: 160]) !== sbx.pop_front()) begin
        fails++;
        $display("FAIL share_xor got %h", got[0 +: 160] ^ got[160 +: 160] ^ got[320 +: 160]);
      end
    end
    tick();
    asserts++;
    if ({in_ready, out_valid, busy} !== 3'b100 || dout !== got) begin
      fails++;
      $display("FAIL handoff in_ready/out_valid/busy got %b exp 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
    asserts++;
    if ({in_ready, out_valid, busy} !== 3'b100 || dout !== '0) begin
      fails++;
      $display("FAIL reset got flags %b dout %h exp 100 / 0", {in_ready, out_valid, busy}, dout);
    end
  endtask

  task automatic test_zero();
    logic [479:0] g;
    accept('0, 0);
    collect(0, g);
  endtask

  task automatic test_single_column();
    logic [479:0] d, e, g;
    d = '0;
    d[0 +: 5] = 5'd1;
    d[40 +: 5] = 5'd2;
    d[80 +: 5] = 5'd4;
    d[120 +: 5] = 5'd8;
    e = '0;
    e[0 +: 5] = 5'd14;
    e[40 +: 5] = 5'd13;
    e[80 +: 5] = 5'd11;
    e[120 +: 5] = 5'd7;
    accept(d, 0);
    collect(0, g);
    asserts++;
    if (g !== e) begin
      fails++;
      $display("FAIL single_column got %h exp %h", g, e);
    end
  endtask

  task automatic test_involution();
    logic [479:0] r, g1, g2;
    for (int k = 0; k < 2; k++) begin
      r = rnd480();
      accept(r, 0);
      collect(0, g1);
      accept(g1, 0);
      collect(0, g2);
      asserts++;
      if (g2 !== r) begin
        fails++;
        $display("FAIL involution got %h exp %h", g2, r);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [479:0] g;
    accept(rnd480(), 0);
    collect(10, g);
  endtask

  task automatic test_reset_mid();
    logic [479:0] g;
    accept(rnd480(), 0);
    for (int i = 0; i < 11; i++) tick();
    rst = 1;
    tick();
    asserts++;
    if ({in_ready, out_valid, busy} !== 3'b100 || dout !== '0) begin
      fails++;
      $display("FAIL reset_mid got flags %b dout %h exp 100 / 0", {in_ready, out_valid, busy}, dout);
    end
    void'(sb.pop_back());
    void'(sbx.pop_back());
    rst = 0;
    tick();
    accept(rnd480(), 0);
    collect(0, g);
  endtask

  task automatic test_back_to_back();
    logic [479:0] g;
    int prev;
    for (int k = 0; k < 3; k++) begin
      accept(rnd480(), 1);
      if (k > 0) begin
        asserts++;
        if (t_acc - prev != 26) begin
          fails++;
          $display("FAIL spacing got %0d cycles exp 26", t_acc - prev);
        end
      end
      prev = t_acc;
      collect(0, g);
    end
    in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_single_column();
    test_involution();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
